// File: rtl/ssc_error_info_pipe.sv
// Two-stage SSC-DSD error-information unit: stage 1 registers syndromes, zero flags and logs,
// stage 2 classifies the triple into NE/CE/DUE with error location and value.
module ssc_error_info_pipe #(
    parameter int         SYM_W     = 8,
    parameter logic [8:0] PRIM_POLY = 9'h15F,
    parameter int         N_DATA    = 36,
    parameter int         CNT_W     = 16,
    localparam int        LOC_W     = $clog2(N_DATA + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] syn0_in,
    input  logic [SYM_W-1:0] syn1_in,
    input  logic [SYM_W-1:0] syn2_in,
    input  logic             detect_only,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOC_W-1:0] err_loc_out,
    output logic [SYM_W-1:0] err_val_out,
    output logic [1:0]       result_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] due_cnt
);

    localparam logic [1:0] RES_NE  = 2'b00;
    localparam logic [1:0] RES_CE  = 2'b01;
    localparam logic [1:0] RES_DUE = 2'b10;

    if (SYM_W != 8) begin : g_sym_w_chk
        $error("ssc_error_info_pipe: only SYM_W=8 is supported");
    end
    if ((N_DATA < 1) || (N_DATA > 252)) begin : g_n_data_chk
        $error("ssc_error_info_pipe: N_DATA must be in 1..252");
    end

    // Entry for symbol x holds log_a(x); entry 0 is unused because log(0) is undefined.
    function automatic logic [2047:0] build_log(input logic [8:0] poly);
        logic [2047:0] tbl;
        logic [8:0]    a;
        tbl = '0;
        a   = 9'd1;
        for (int k = 0; k < 255; k++) begin
            tbl[a[7:0]*8 +: 8] = 8'(k);
            a = {a[7:0], 1'b0};
            if (a[8]) begin
                a = a ^ poly;
            end else begin
                a = a;
            end
        end
        return tbl;
    endfunction

    localparam logic [2047:0] LOG_TBL = build_log(PRIM_POLY);

    function automatic logic [7:0] sub_mod255(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} + 9'd255 - {1'b0, b};
        if (d >= 9'd255) begin
            d = d - 9'd255;
        end else begin
            d = d;
        end
        return d[7:0];
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_syn0_q, s1_syn0_d, s1_syn1_q, s1_syn1_d, s1_syn2_q, s1_syn2_d;
    logic [2:0]       s1_zero_q, s1_zero_d;
    logic [7:0]       s1_log0_q, s1_log0_d, s1_log1_q, s1_log1_d, s1_log2_q, s1_log2_d;
    logic             s1_det_q, s1_det_d;
    logic             out_valid_q, out_valid_d;
    logic [LOC_W-1:0] err_loc_q, err_loc_d;
    logic [7:0]       err_val_q, err_val_d;
    logic [1:0]       result_q, result_d;
    logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d, due_cnt_q, due_cnt_d;
    logic             s1_en_s, s2_en_s, out_hs_s;
    logic [7:0]       j1_s, j2_s;
    logic [1:0]       cls_res_s;
    logic [LOC_W-1:0] cls_loc_s;
    logic [7:0]       cls_val_s;

    // Stage 2 moves unless its held result is refused; stage 1 refills when empty or draining.
    always_comb begin
        s2_en_s  = !out_valid_q || out_ready;
        s1_en_s  = !s1_valid_q || s2_en_s;
        out_hs_s = out_valid_q && out_ready;
        in_ready = !rst && s1_en_s;
    end

    // Stage 1 capture: syndromes, zero flags and logs.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_syn0_d  = s1_syn0_q;
        s1_syn1_d  = s1_syn1_q;
        s1_syn2_d  = s1_syn2_q;
        s1_zero_d  = s1_zero_q;
        s1_log0_d  = s1_log0_q;
        s1_log1_d  = s1_log1_q;
        s1_log2_d  = s1_log2_q;
        s1_det_d   = s1_det_q;
        if (s1_en_s) begin
            s1_valid_d = in_valid;
            s1_syn0_d  = syn0_in;
            s1_syn1_d  = syn1_in;
            s1_syn2_d  = syn2_in;
            s1_zero_d  = {syn0_in == 8'h00, syn1_in == 8'h00, syn2_in == 8'h00};
            s1_log0_d  = LOG_TBL[{syn0_in, 3'b000} +: 8];
            s1_log1_d  = LOG_TBL[{syn1_in, 3'b000} +: 8];
            s1_log2_d  = LOG_TBL[{syn2_in, 3'b000} +: 8];
            s1_det_d   = detect_only;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Classification of the stage-1 triple by its zero pattern {z0,z1,z2}.
    always_comb begin
        j1_s      = sub_mod255(s1_log1_q, s1_log0_q);
        j2_s      = sub_mod255(s1_log2_q, s1_log1_q);
        cls_res_s = RES_DUE;
        cls_loc_s = '0;
        cls_val_s = 8'h00;
        case (s1_zero_q)
            3'b111: cls_res_s = RES_NE;
            3'b011: begin
                cls_res_s = RES_CE;
                cls_loc_s = LOC_W'(N_DATA);
                cls_val_s = s1_syn0_q;
            end
            3'b101: begin
                cls_res_s = RES_CE;
                cls_loc_s = LOC_W'(N_DATA + 1);
                cls_val_s = s1_syn1_q;
            end
            3'b110: begin
                cls_res_s = RES_CE;
                cls_loc_s = LOC_W'(N_DATA + 2);
                cls_val_s = s1_syn2_q;
            end
            3'b000: begin
                if ((j1_s == j2_s) && ({24'd0, j1_s} < 32'(N_DATA))) begin
                    cls_res_s = RES_CE;
                    cls_loc_s = LOC_W'(j1_s);
                    cls_val_s = s1_syn0_q;
                end else begin
                    cls_res_s = RES_DUE;
                end
            end
            default: cls_res_s = RES_DUE;
        endcase
        if (s1_det_q && (cls_res_s != RES_NE)) begin
            cls_res_s = RES_DUE;
            cls_loc_s = '0;
            cls_val_s = 8'h00;
        end else begin
            cls_res_s = cls_res_s;
        end
    end

    // Stage 2 output register; an empty stage 1 loads zeros so no stale fields linger.
    always_comb begin
        out_valid_d = out_valid_q;
        err_loc_d   = err_loc_q;
        err_val_d   = err_val_q;
        result_d    = result_q;
        if (s2_en_s) begin
            out_valid_d = s1_valid_q;
            err_loc_d   = s1_valid_q ? cls_loc_s : '0;
            err_val_d   = s1_valid_q ? cls_val_s : 8'h00;
            result_d    = s1_valid_q ? cls_res_s : RES_NE;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_comb begin
        ce_cnt_d  = ce_cnt_q;
        due_cnt_d = due_cnt_q;
        if (cnt_clr) begin
            ce_cnt_d  = '0;
            due_cnt_d = '0;
        end else if (out_hs_s && (result_q == RES_CE) && (ce_cnt_q != '1)) begin
            ce_cnt_d = ce_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (out_hs_s && (result_q == RES_DUE) && (due_cnt_q != '1)) begin
            due_cnt_d = due_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ce_cnt_d = ce_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_syn0_q   <= 8'h00;
            s1_syn1_q   <= 8'h00;
            s1_syn2_q   <= 8'h00;
            s1_zero_q   <= 3'b111;
            s1_log0_q   <= 8'h00;
            s1_log1_q   <= 8'h00;
            s1_log2_q   <= 8'h00;
            s1_det_q    <= 1'b0;
            out_valid_q <= 1'b0;
            err_loc_q   <= '0;
            err_val_q   <= 8'h00;
            result_q    <= RES_NE;
            ce_cnt_q    <= '0;
            due_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_syn0_q   <= s1_syn0_d;
            s1_syn1_q   <= s1_syn1_d;
            s1_syn2_q   <= s1_syn2_d;
            s1_zero_q   <= s1_zero_d;
            s1_log0_q   <= s1_log0_d;
            s1_log1_q   <= s1_log1_d;
            s1_log2_q   <= s1_log2_d;
            s1_det_q    <= s1_det_d;
            out_valid_q <= out_valid_d;
            err_loc_q   <= err_loc_d;
            err_val_q   <= err_val_d;
            result_q    <= result_d;
            ce_cnt_q    <= ce_cnt_d;
            due_cnt_q   <= due_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign err_loc_out = err_loc_q;
    assign err_val_out = SYM_W'(err_val_q);
    assign result_out  = result_q;
    assign ce_cnt      = ce_cnt_q;
    assign due_cnt     = due_cnt_q;

endmodule

// File: tb/tb_ssc_error_info_pipe.sv
// Directed bench for ssc_error_info_pipe (N_DATA=36, CNT_W=2 so saturation is reachable).
module tb_ssc_error_info_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, detect_only, out_valid, out_ready, cnt_clr;
    logic [7:0] syn0, syn1, syn2, err_val;
    logic [5:0] err_loc;
    logic [1:0] result;
    logic [1:0] ce_cnt, due_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] st_s0 [4];
    logic [7:0] st_s1 [4];
    logic [7:0] st_s2 [4];
    logic [5:0] st_loc[4];
    logic [7:0] st_val[4];

    always #5 clk = ~clk;

    ssc_error_info_pipe #(.SYM_W(8), .PRIM_POLY(9'h15F), .N_DATA(36), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .syn0_in(syn0), .syn1_in(syn1), .syn2_in(syn2), .detect_only(detect_only),
        .out_valid(out_valid), .out_ready(out_ready), .err_loc_out(err_loc),
        .err_val_out(err_val), .result_out(result), .cnt_clr(cnt_clr),
        .ce_cnt(ce_cnt), .due_cnt(due_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One triple through the pipe with out_ready high; clr pulses cnt_clr on the output handshake.
    task automatic run_one(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic det, input logic clr,
                           input logic [1:0] er, input logic [5:0] el, input logic [7:0] ev);
        syn0 = s0; syn1 = s1; syn2 = s2; detect_only = det;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0; detect_only = 1'b0; syn0 = 8'h00; syn1 = 8'h00; syn2 = 8'h00;
        chk({tag, "_lat1"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_loc"}, err_loc, el);
        chk({tag, "_val"}, err_val, ev);
        cnt_clr = clr;
        tick();
        cnt_clr = 1'b0;
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        int sent, got, stall;
        logic first;
        logic [15:0] snap;

        st_s0 = '{8'h5A, 8'h00, 8'h00, 8'h01};
        st_s1 = '{8'h00, 8'h00, 8'h7E, 8'h20};
        st_s2 = '{8'h00, 8'hC3, 8'h00, 8'h23};
        st_loc = '{6'd36, 6'd38, 6'd37, 6'd5};
        st_val = '{8'h5A, 8'hC3, 8'h7E, 8'h01};

        rst = 1'b1; in_valid = 1'b0; detect_only = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        syn0 = 8'h00; syn1 = 8'h00; syn2 = 8'h00;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        chk("rst_res", result, 2'b00);
        chk("rst_loc", err_loc, 6'd0);
        chk("rst_val", err_val, 8'h00);
        chk("rst_ce", ce_cnt, 2'd0);
        chk("rst_due", due_cnt, 2'd0);

        run_one("ne", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 6'd0, 8'h00);
        chk("ne_ce", ce_cnt, 2'd0);
        chk("ne_due", due_cnt, 2'd0);
        run_one("ce_s0", 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 6'd36, 8'h5A);
        chk("ce_s0_cnt", ce_cnt, 2'd1);
        run_one("ce_s2", 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0, 2'b01, 6'd38, 8'hC3);
        chk("ce_s2_cnt", ce_cnt, 2'd2);
        run_one("ce_s1", 8'h00, 8'h7E, 8'h00, 1'b0, 1'b0, 2'b01, 6'd37, 8'h7E);
        chk("ce_s1_cnt", ce_cnt, 2'd3);
        run_one("ce_sym5", 8'h01, 8'h20, 8'h23, 1'b0, 1'b0, 2'b01, 6'd5, 8'h01);
        chk("ce_sat", ce_cnt, 2'd3);
        chk("ce_sym5_due", due_cnt, 2'd0);

        run_one("det", 8'h01, 8'h20, 8'h23, 1'b1, 1'b0, 2'b10, 6'd0, 8'h00);
        chk("det_due", due_cnt, 2'd1);
        run_one("due_j", 8'h01, 8'h20, 8'h20, 1'b0, 1'b0, 2'b10, 6'd0, 8'h00);
        chk("due_j_cnt", due_cnt, 2'd2);
        run_one("due_z2a", 8'h01, 8'h20, 8'h00, 1'b0, 1'b0, 2'b10, 6'd0, 8'h00);
        chk("due_z2a_cnt", due_cnt, 2'd3);
        run_one("due_z2b", 8'h01, 8'h20, 8'h00, 1'b0, 1'b0, 2'b10, 6'd0, 8'h00);
        run_one("due_z2c", 8'h01, 8'h20, 8'h00, 1'b0, 1'b0, 2'b10, 6'd0, 8'h00);
        chk("due_sat", due_cnt, 2'd3);
        chk("due_sat_ce", ce_cnt, 2'd3);

        run_one("clr", 8'h01, 8'h20, 8'h00, 1'b0, 1'b1, 2'b10, 6'd0, 8'h00);
        chk("clr_due", due_cnt, 2'd0);
        chk("clr_ce", ce_cnt, 2'd0);

        // Back-to-back stream with a three-cycle downstream stall at the first result.
        sent = 0; got = 0; stall = 0; first = 1'b0; snap = 16'h0000;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            syn0 = (sent < 4) ? st_s0[sent] : 8'h00;
            syn1 = (sent < 4) ? st_s1[sent] : 8'h00;
            syn2 = (sent < 4) ? st_s2[sent] : 8'h00;
            if (out_valid) first = 1'b1;
            out_ready = !(first && (stall < 3));
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (stall > 0) chk("stall_hold", {result, err_loc, err_val}, snap);
                snap = {result, err_loc, err_val};
                stall++;
            end
            if (out_valid && out_ready && got < 4) begin
                chk("stream_res", result, 2'b01);
                chk("stream_loc", err_loc, st_loc[got]);
                chk("stream_val", err_val, st_val[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_got", got, 4);
        chk("stream_stalls", stall, 3);
        tick();
        chk("stream_no_dup", out_valid, 0);
        chk("stream_ce", ce_cnt, 2'd3);
        chk("stream_due", due_cnt, 2'd0);

        // Reset in the middle of a stream flushes everything.
        syn0 = 8'h5A; syn1 = 8'h00; syn2 = 8'h00; in_valid = 1'b1;
        tick();
        tick();
        chk("mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_res", result, 2'b00);
        chk("mid_rst_loc", err_loc, 6'd0);
        chk("mid_rst_val", err_val, 8'h00);
        chk("mid_rst_ce", ce_cnt, 2'd0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_post_valid1", out_valid, 0);
        tick();
        chk("mid_post_valid2", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
